// File: rtl/logic_pkg.sv
// Shared types and pointer helpers for the gray-coded pointer crossing.
// Helpers work on zero-extended values, so one function serves every pointer width up to MAX_PTR_W.
package logic_pkg;

  localparam int unsigned MAX_PTR_W = 32;

  typedef enum logic {WRITE_SIDE, READ_SIDE} mode_t;
  typedef enum logic {TARGET_GENERIC, TARGET_FPGA} target_t;

  function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
    logic [MAX_PTR_W-1:0] b;
    b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
    for (int i = int'(MAX_PTR_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic int unsigned popcount(input logic [MAX_PTR_W-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < int'(MAX_PTR_W); i++) begin
      c += 32'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/logic_clock_domain_crossing_generic_synchronizer.sv
// Bare multi-flop synchronizer chain; kept separate so per-target sync attributes live in one place.
module logic_clock_domain_crossing_generic_synchronizer
  import logic_pkg::*;
#(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned STAGES = 2,
  parameter target_t     TARGET = TARGET_GENERIC
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("synchronizer STAGES must be within 2..4");
  end

  if (TARGET == TARGET_FPGA) begin : g_fpga
    (* async_reg = "true" *) logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
        for (int i = 0; i < int'(STAGES); i++) chain[i] <= '0;
      end else begin
        chain[0] <= d;
        for (int i = 1; i < int'(STAGES); i++) chain[i] <= chain[i-1];
      end
    end

    assign q = chain[STAGES-1];
  end else begin : g_generic
    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
        for (int i = 0; i < int'(STAGES); i++) chain[i] <= '0;
      end else begin
        chain[0] <= d;
        for (int i = 1; i < int'(STAGES); i++) chain[i] <= chain[i-1];
      end
    end

    assign q = chain[STAGES-1];
  end

endmodule

// File: rtl/blk_c52d38.sv
// Receiving half of an async FIFO pointer crossing: sync, gray->binary, occupancy and flag,
// plus detection of corrupted crossings (multi-bit gray jumps or pointer overrun).
module blk_c52d38
  import logic_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned STAGES        = 2,
  parameter mode_t       MODE          = WRITE_SIDE,
  parameter target_t     TARGET        = TARGET_GENERIC
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [ADDRESS_WIDTH:0] remote_pointer,
  input  logic [ADDRESS_WIDTH:0] local_pointer,
  input  logic                   error_clear,
  output logic [ADDRESS_WIDTH:0] remote_pointer_synced,
  output logic [ADDRESS_WIDTH:0] used,
  output logic [ADDRESS_WIDTH:0] free,
  output logic                   flag,
  output logic                   error,
  output logic                   error_sticky
);

  localparam int unsigned   PW       = ADDRESS_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH    = {1'b1, {ADDRESS_WIDTH{1'b0}}};
  localparam logic          FLAG_RST = (MODE == READ_SIDE);

  if (PW > MAX_PTR_W) begin : g_bad_width
    $error("ADDRESS_WIDTH too large for pointer helpers");
  end

  logic [PW-1:0] g_s;
  logic [PW-1:0] g_q;
  logic [PW-1:0] bin_c;
  logic [PW-1:0] diff_c;
  logic          multi_bit_c;
  logic          overrun_c;
  logic          err_c;
  logic          flag_c;

  logic_clock_domain_crossing_generic_synchronizer #(
    .WIDTH  (PW),
    .STAGES (STAGES),
    .TARGET (TARGET)
  ) u_sync (
    .aclk   (aclk),
    .areset (areset),
    .d      (remote_pointer),
    .q      (g_s)
  );

  // Modulo-2**PW difference keeps occupancy correct across the pointer wrap.
  always_comb begin
    bin_c       = PW'(gray2bin(MAX_PTR_W'(g_q)));
    diff_c      = (MODE == WRITE_SIDE) ? (local_pointer - remote_pointer_synced)
                                       : (remote_pointer_synced - local_pointer);
    multi_bit_c = popcount(MAX_PTR_W'(g_s ^ g_q)) > 1;
    overrun_c   = diff_c > DEPTH;
    err_c       = multi_bit_c | overrun_c;
    flag_c      = (MODE == WRITE_SIDE) ? (diff_c == DEPTH) : (diff_c == '0);
  end

  // A fresh error on the same edge as error_clear keeps the sticky bit set.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      g_q                   <= '0;
      remote_pointer_synced <= '0;
      used                  <= '0;
      free                  <= DEPTH;
      flag                  <= FLAG_RST;
      error                 <= 1'b0;
      error_sticky          <= 1'b0;
    end else begin
      g_q                   <= g_s;
      remote_pointer_synced <= bin_c;
      used                  <= diff_c;
      free                  <= DEPTH - diff_c;
      flag                  <= flag_c;
      error                 <= err_c;
      error_sticky          <= err_c | (error_sticky & ~error_clear);
    end
  end

endmodule

// File: doc/blk_c52d38.md
Name: logic_clock_domain_crossing_generic_pointer_receiver

Overview:
- Receiving half of a gray-coded FIFO pointer crossing: takes a pointer from the remote clock domain and synchronises it into the local domain.
- Synchronizer depth is configurable.
- Converts the synced pointer to binary and compares it against the local binary pointer to produce the occupancy count and the full or empty flag.
- Detects corrupted crossings, i.e. more than one gray bit changing between samples.
- Instantiated twice per async FIFO: once with MODE=WRITE_SIDE, once with MODE=READ_SIDE.

Parameters:
- ADDRESS_WIDTH, 4: FIFO address bits. Pointers are ADDRESS_WIDTH+1 bits; the MSB is the wrap bit. Depth is 2**ADDRESS_WIDTH.
- STAGES, 2: synchronizer flops. Legal range 2..4; elaboration error outside it.
- MODE, logic_pkg::WRITE_SIDE: WRITE_SIDE means local is the write pointer and the flag is full. READ_SIDE means local is the read pointer and the flag is empty.
- TARGET, logic_pkg::TARGET_GENERIC: technology selector, passed to the sync sub-module.

Ports:
- aclk, input, 1: local clock; the only clock.
- areset, input, 1: asynchronous, active-high reset.
- remote_pointer, input, ADDRESS_WIDTH+1: gray pointer from the remote domain; asynchronous to aclk.
- local_pointer, input, ADDRESS_WIDTH+1: local binary pointer, synchronous to aclk.
- error_clear, input, 1: clears error_sticky.
- remote_pointer_synced, output, ADDRESS_WIDTH+1: synced remote pointer in binary.
- used, output, ADDRESS_WIDTH+1: occupied entries, range 0..2**ADDRESS_WIDTH.
- free, output, ADDRESS_WIDTH+1: 2**ADDRESS_WIDTH - used.
- flag, output, 1: full (WRITE_SIDE) or empty (READ_SIDE).
- error, output, 1: one-cycle pulse on a detected fault.
- error_sticky, output, 1: latched error.

Behaviour:
- Reset (areset=1, async assert; deassert is synchronous to the design's reset synchronizer):
  - All sync flops, the gray register and remote_pointer_synced go to 0.
  - used=0, free=2**ADDRESS_WIDTH.
  - flag=0 for WRITE_SIDE, 1 for READ_SIDE.
  - error=0, error_sticky=0.
- Sync chain: STAGES flops clocked on aclk, no logic between them; output is the gray value g_s.
- Stage G: register g_s into g_q. Convert g_q to binary, b[i] = XOR of g_q[N-1:i], and register it into remote_pointer_synced.
- Latency: a stable remote_pointer change appears on remote_pointer_synced after STAGES+2 aclk edges.
- Occupancy, registered one cycle after its inputs, computed modulo 2**(ADDRESS_WIDTH+1):
  - WRITE_SIDE: used = local_pointer - remote_pointer_synced.
  - READ_SIDE: used = remote_pointer_synced - local_pointer.
  - A change on local_pointer is reflected on used/free/flag one cycle later.
- Flag: full when used == 2**ADDRESS_WIDTH (MSBs differ, lower bits equal). Empty when used == 0. The flag is registered together with used, never combinational.
- Wrap-around: pointer 2**(ADDRESS_WIDTH+1)-1 -> 0 is a legal single-bit gray step. Modulo subtraction keeps used correct across the wrap.
- Error detection: error=1 for one cycle when either condition holds:
  - popcount(g_s XOR g_q) > 1 (multi-bit gray jump);
  - the raw difference exceeds 2**ADDRESS_WIDTH (pointer overrun).
  - On error, outputs still update with the sampled value; no filtering.
- error_sticky: set on error, cleared by error_clear. If error and error_clear occur in the same cycle, set wins.
- Reset mid-operation: all state returns to reset values immediately. The first sample after release is compared against g_q=0, so a nonzero remote pointer after a one-sided reset flags an error. This is intended: both domains must reset together.

Decomposition:
- logic_pkg holds:
  - the mode_t enum {WRITE_SIDE, READ_SIDE};
  - gray2bin and bin2gray functions parametrised by width;
  - a popcount function.
- Sub-module logic_clock_domain_crossing_generic_synchronizer (WIDTH, STAGES, TARGET): the bare flop chain with async active-high reset, isolated so vendor-specific sync attributes can be applied per TARGET.

Test Plan:
- Reset, both modes, ADDRESS_WIDTH=4 -> used=0, free=16; flag=0 (WRITE_SIDE), flag=1 (READ_SIDE); no error.
- READ_SIDE, STAGES=2: remote steps gray 0->1->3->2 (binary 0..3), local=0 -> remote_pointer_synced=3 four edges after the last step; used=3, free=13; flag falls to 0.
- WRITE_SIDE: local=16 (binary 10000), remote gray for 0 -> used=16, flag=1. Remote advances to 1 -> used=15, flag=0 after STAGES+3 edges.
- Wrap: remote counts 30->31->0->1 in gray, local=30 (READ_SIDE) -> used goes 0,1,2,3, no error.
- Remote jumps gray 0 -> 0b00011_inverted (multi-bit change) -> error pulses 1 cycle, error_sticky=1. Simultaneous error_clear on the same cycle -> sticky stays 1. Clear on the next cycle -> 0.
- STAGES=3 and STAGES=4 regressions: measured latency is STAGES+2 edges. Assert areset mid-count -> all outputs return to reset values within the same cycle.
